div16_by8_seq: RTL and testbench



---
 rtl/div16_by8_seq.sv | 106 ++++++++++
 tb/tb_div16_by8_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/div16_by8_seq.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient
// bit per clock, start/done handshake. Divide-by-zero returns a saturated
// quotient and flags dbz without iterating.
module div16_by8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        busy,
  output logic        done,
  output logic        dbz
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] d;        // dividend shifter, fills with quotient bits
  logic [7:0]  dv;       // captured divisor
  logic [7:0]  p;        // partial remainder; always < dv, so bit 8 is never set
  logic [3:0]  cnt;      // iterations remaining after the current one

  logic [8:0]  t;        // 9-bit trial value {P, next dividend bit}
  logic        q_bit;
  logic [7:0]  p_next;
  logic [15:0] d_next;

  // One restoring step: shift in a dividend bit, subtract if it fits.
  always_comb begin
    t      = {p, d[15]};
    q_bit  = (t >= {1'b0, dv});
    // When the subtraction is taken the true result is below dv, so the
    // low 8 bits of the modular difference are exact.
    p_next = q_bit ? (t[7:0] - dv) : t[7:0];
    d_next = {d[14:0], q_bit};
  end

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: datapath registers are cleared too so an aborted divide leaves
      // no stale operands behind; they are ordinary flops, not memory.
      state <= S_IDLE;
      d     <= '0;
      dv    <= '0;
      p     <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of state, cnt, d and p.
      done <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (B == 8'd0) begin
              state <= S_DONE;
              Q     <= 16'hFFFF;
              R     <= A[7:0];
              dbz   <= 1'b1;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              d     <= A;
              dv    <= B;
              p     <= '0;
              cnt   <= 4'd15;
              busy  <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          d <= d_next;
          p <= p_next;
          if (cnt == 4'd0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Q     <= d_next;
            R     <= p_next;
            dbz   <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div16_by8_seq.sv
// Self-checking bench for div16_by8_seq: directed vector table, multi-cycle
// corner sequences, and randomized back-to-back divides against an
// arithmetic reference model.
module tb_div16_by8_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [7:0]  B;
  logic [15:0] Q;
  logic [7:0]  R;
  logic        busy;
  logic        done;
  logic        dbz;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int TIMEOUT   = 40;
  localparam int N_RANDOM  = 2000;

  div16_by8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Apply one start pulse and wait for done; reports edges from the accepting
  // edge (counted as 1) to the done cycle, and how many of those had busy high.
  task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                         output int lat, output int busy_cnt);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_cnt = 0;
    while (!done && lat < TIMEOUT) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1'b1);
    check("busy_low_in_done", busy, 1'b0);
  endtask

  initial begin
    int lat, bcnt, done_pulses, cyc;
    logic [15:0] ra, exp_q;
    logic [7:0]  rb, exp_r;

    vecs[0] = '{a: 16'd38000, b: 8'd190, q: 16'd200,   r: 8'd0,   dbz: 1'b0};
    vecs[1] = '{a: 16'd65535, b: 8'd255, q: 16'd257,   r: 8'd0,   dbz: 1'b0};
    vecs[2] = '{a: 16'd65535, b: 8'd1,   q: 16'd65535, r: 8'd0,   dbz: 1'b0};
    vecs[3] = '{a: 16'd1000,  b: 8'd7,   q: 16'd142,   r: 8'd6,   dbz: 1'b0};
    vecs[4] = '{a: 16'd100,   b: 8'd200, q: 16'd0,     r: 8'd100, dbz: 1'b0};
    vecs[5] = '{a: 16'd0,     b: 8'd5,   q: 16'd0,     r: 8'd0,   dbz: 1'b0};
    vecs[6] = '{a: 16'd1234,  b: 8'd0,   q: 16'hFFFF,  r: 8'hD2,  dbz: 1'b1};
    vecs[7] = '{a: 16'd10,    b: 8'd3,   q: 16'd3,     r: 8'd1,   dbz: 1'b0};

    // Reset state
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst_Q", Q, 0);
    check("rst_R", R, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", dbz, 0);
    rst_n = 1'b1;

    // Directed vectors, including divide-by-zero and the divide after it
    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("vec%0d_Q", i), Q, vecs[i].q);
      check($sformatf("vec%0d_R", i), R, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), dbz, vecs[i].dbz);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].dbz ? 1 : 17);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].dbz ? 0 : 16);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), done, 0);
      check($sformatf("vec%0d_result_held", i), Q, vecs[i].q);
    end

    // start and operand changes during RUN are ignored; previous result held
    @(negedge clk);
    A = 16'd500; B = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_pulses = 0;
    for (int c = 1; c <= 30; c++) begin
      if (done) done_pulses++;
      if (c == 5) begin
        check("run_Q_held", Q, 16'd3);
        check("run_busy", busy, 1'b1);
        A = 16'd9; B = 8'd3; start = 1'b1;
      end else if (c == 6) begin
        start = 1'b0;
      end else if (c == 8) begin
        A = 16'd4321; B = 8'd11;
      end
      @(negedge clk);
    end
    check("ignore_Q", Q, 16'd71);
    check("ignore_R", R, 8'd3);
    check("ignore_done_pulses", done_pulses, 1);

    // Reset in the middle of a divide
    @(negedge clk);
    A = 16'd38000; B = 8'd190; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_Q", Q, 0);
    check("midrst_R", R, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done) check("midrst_no_late_done", done, 1'b0);
    end
    run_div(16'd255, 8'd16, lat, bcnt);
    check("post_rst_Q", Q, 16'd15);
    check("post_rst_R", R, 8'd15);
    @(negedge clk);

    // Random back-to-back divides with start held through each done cycle
    ra = 16'($urandom); rb = 8'($urandom_range(1, 255));
    A = ra; B = rb; start = 1'b1;
    for (int i = 0; i < N_RANDOM; i++) begin
      @(negedge clk);
      cyc = 1;
      while (!done && cyc < TIMEOUT) begin
        @(negedge clk);
        cyc++;
      end
      exp_q = ra / 16'(rb);
      exp_r = 8'(ra % 16'(rb));
      check("rand_spacing", cyc, 17);
      check("rand_Q", Q, exp_q);
      check("rand_R", R, exp_r);
      check("rand_identity", 32'(Q) * 32'(rb) + 32'(R), 32'(ra));
      check("rand_R_lt_B", (R < rb), 1'b1);
      check("rand_no_busy_with_done", busy, 1'b0);
      if (i == N_RANDOM - 1) begin
        start = 1'b0;
      end else begin
        ra = 16'($urandom); rb = 8'($urandom_range(1, 255));
        A = ra; B = rb;
      end
    end
    @(negedge clk);
    check("final_idle_done", done, 0);
    check("final_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
